// File: rtl/dsm_filter_pkg.sv
// Shared constants, coefficient table and FSM state type for the CIC droop
// compensation FIR (dsm_comp_fir_dec2) and its sample buffer.
package dsm_filter_pkg;

  localparam int unsigned IN_W      = 24;
  localparam int unsigned OUT_W     = 24;
  localparam int unsigned COEF_W    = 12;
  localparam int unsigned COEF_FRAC = 11;
  localparam int unsigned N_TAPS    = 16;  // power of two: pointers wrap naturally
  localparam int unsigned DEC       = 2;

  // Accumulator width that can never wrap for full-scale input on every tap.
  function automatic int unsigned acc_w(input int unsigned in_w,
                                        input int unsigned coef_w,
                                        input int unsigned n_taps);
    return in_w + coef_w + $clog2(n_taps);
  endfunction

  localparam int unsigned ACC_W = acc_w(IN_W, COEF_W, N_TAPS);
  localparam int unsigned PTR_W = $clog2(N_TAPS);
  localparam int unsigned PH_W  = (DEC > 1) ? $clog2(DEC) : 1;

  typedef logic signed [COEF_W-1:0] coef_t;

  // Symmetric Q1.11 droop compensation; sum = 2048 (unity DC gain).
  // Index 0 multiplies the newest sample.
  localparam coef_t COEF [N_TAPS] = '{
    -12'sd5,  -12'sd11,  12'sd18,  12'sd40, -12'sd64, -12'sd96, 12'sd250, 12'sd892,
    12'sd892,  12'sd250, -12'sd96, -12'sd64, 12'sd40,  12'sd18, -12'sd11, -12'sd5
  };

  typedef enum logic [1:0] {IDLE, MAC, ROUND} state_e;

endpackage

// File: rtl/dsm_comp_fir_dec2_if.sv
// Sample-in / filtered-sample-out bundle of the compensation FIR.
// master: producer of CIC samples and consumer of results (bench / upstream).
// slave : the filter itself.
interface dsm_comp_fir_dec2_if;
  import dsm_filter_pkg::*;

  logic [IN_W-1:0]  in_data;
  logic             in_valid;
  logic [OUT_W-1:0] out_data;
  logic             out_valid;
  logic             busy;
  logic             overrun;
  logic             sat;

  modport master (output in_data, in_valid,
                  input  out_data, out_valid, busy, overrun, sat);
  modport slave  (input  in_data, in_valid,
                  output out_data, out_valid, busy, overrun, sat);
endinterface

// File: rtl/dsm_fir_sample_buf.sv
// N_TAPS x IN_W circular sample store: one write port, one asynchronous read
// port, plus a per-entry valid mask so never-written entries read as absent.
// Ports: clk, rst_n (sync, active-low, clears mask only), wr_en_i/wr_addr_i/
// wr_data_i write port, rd_addr_i read address, rd_data_c_o/rd_valid_c_o
// combinational read data and entry-valid flag.
module dsm_fir_sample_buf
  import dsm_filter_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_en_i,
  input  logic [PTR_W-1:0]        wr_addr_i,
  input  logic signed [IN_W-1:0]  wr_data_i,
  input  logic [PTR_W-1:0]        rd_addr_i,
  output logic signed [IN_W-1:0]  rd_data_c_o,
  output logic                    rd_valid_c_o
);

  logic signed [IN_W-1:0] mem_q [N_TAPS];
  logic [N_TAPS-1:0]      mask_q;

  // Sample storage is deliberately not reset; the mask hides stale entries.
  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)       mask_q            <= '0;
    else if (wr_en_i) mask_q[wr_addr_i] <= 1'b1;
  end

  assign rd_data_c_o  = mem_q[rd_addr_i];
  assign rd_valid_c_o = mask_q[rd_addr_i];

endmodule

// File: rtl/dsm_comp_fir_dec2.sv
// CIC droop compensation FIR with decimation by DEC. One MAC per clk over
// N_TAPS cycles, then a round/saturate cycle producing one signed sample.
// Ports: clk, rst_n (sync, active-low), bus (slave modport): in_data/in_valid
// sample strobe; out_data/out_valid result; busy while computing; overrun
// sticky dropped-sample flag; sat marks a clipped result.
module dsm_comp_fir_dec2
  import dsm_filter_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  dsm_comp_fir_dec2_if.slave bus
);

  localparam logic signed [ACC_W-1:0] HALF_LSB = ACC_W'(2 ** (COEF_FRAC - 1));

  state_e                  state_q, state_d;
  logic [PTR_W-1:0]        wptr_q, wptr_d, k_q, k_d;
  logic [PH_W-1:0]         phase_q, phase_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [OUT_W-1:0]        out_data_q, out_data_d;
  logic                    out_valid_q, out_valid_d;
  logic                    sat_q, sat_d;
  logic                    busy_q, busy_d;
  logic                    overrun_q, overrun_d;

  logic                    wr_en_c;
  logic signed [IN_W-1:0]  s_c, rd_data_c, tap_c;
  logic                    rd_valid_c;
  logic [PTR_W-1:0]        rd_addr_c;
  logic signed [ACC_W-1:0] prod_c, rnd_c, r_c;
  logic                    fits_c;
  logic [OUT_W-1:0]        clip_c;

  // Offset binary -> two's complement (midscale maps to 0).
  assign s_c = {~bus.in_data[IN_W-1], bus.in_data[IN_W-2:0]};

  // Tap k reads the sample k positions older than the newest one.
  assign rd_addr_c = wptr_q - PTR_W'(1) - k_q;

  dsm_fir_sample_buf u_buf (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_en_i      (wr_en_c),
    .wr_addr_i    (wptr_q),
    .wr_data_i    (s_c),
    .rd_addr_i    (rd_addr_c),
    .rd_data_c_o  (rd_data_c),
    .rd_valid_c_o (rd_valid_c)
  );

  assign tap_c  = rd_valid_c ? rd_data_c : '0;
  assign prod_c = ACC_W'(tap_c) * ACC_W'(COEF[k_q]);

  // Round half toward +inf, then clip to the signed output range.
  assign rnd_c  = acc_q + HALF_LSB;
  assign r_c    = rnd_c >>> COEF_FRAC;
  assign fits_c = (&r_c[ACC_W-1:OUT_W-1]) | ~(|r_c[ACC_W-1:OUT_W-1]);
  assign clip_c = fits_c      ? r_c[OUT_W-1:0] :
                  r_c[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} :
                                 {1'b0, {(OUT_W-1){1'b1}}};

  // Next-state, sample intake and output logic.
  always_comb begin
    state_d     = state_q;
    wptr_d      = wptr_q;
    k_d         = k_q;
    phase_d     = phase_q;
    acc_d       = acc_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    sat_d       = 1'b0;
    overrun_d   = overrun_q;
    wr_en_c     = 1'b0;

    if (bus.in_valid) begin
      if (busy_q) begin
        overrun_d = 1'b1;
      end else begin
        wr_en_c = 1'b1;
        wptr_d  = wptr_q + PTR_W'(1);
        phase_d = (phase_q == PH_W'(DEC - 1)) ? '0 : phase_q + PH_W'(1);
      end
    end

    case (state_q)
      IDLE: begin
        // busy_q is low in IDLE, so any strobe here is accepted.
        if (bus.in_valid && (phase_q == PH_W'(DEC - 1))) begin
          state_d = MAC;
          acc_d   = '0;
          k_d     = '0;
        end
      end
      MAC: begin
        acc_d = acc_q + prod_c;
        k_d   = k_q + PTR_W'(1);
        if (k_q == PTR_W'(N_TAPS - 1)) state_d = ROUND;
      end
      ROUND: begin
        out_data_d  = clip_c;
        out_valid_d = 1'b1;
        sat_d       = ~fits_c;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_d = (state_d != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wptr_q      <= '0;
      k_q         <= '0;
      phase_q     <= '0;
      acc_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      sat_q       <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wptr_q      <= wptr_d;
      k_q         <= k_d;
      phase_q     <= phase_d;
      acc_q       <= acc_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      sat_q       <= sat_d;
      busy_q      <= busy_d;
      overrun_q   <= overrun_d;
    end
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sat       = sat_q;
  assign bus.busy      = busy_q;
  assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_dsm_comp_fir_dec2.sv
// Directed + random bench for dsm_comp_fir_dec2. Expected outputs are pushed
// to a scoreboard queue when the completing strobe is driven and popped by a
// monitor when out_valid appears.
module tb_dsm_comp_fir_dec2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dsm_comp_fir_dec2_if bus ();

  dsm_comp_fir_dec2 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [23:0] d;
    logic        s;
    int unsigned e;
  } exp_t;

  int tb_coef [16] = '{-5, -11, 18, 40, -64, -96, 250, 892,
                       892, 250, -96, -64, 40, 18, -11, -5};

  exp_t        sb [$];
  int          hist [$];
  int unsigned phase = 0;
  int unsigned free_edge = 0;
  int unsigned cyc = 0;
  int          errors = 0;
  int          checks = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Bit-exact reference: 16-tap dot product, round half up, clip to 24 bits.
  function automatic void model(output logic [23:0] d, output logic s);
    longint acc = 0;
    longint r;
    foreach (hist[k]) acc += longint'(hist[k]) * longint'(tb_coef[k]);
    r = (acc + 1024) >>> 11;
    if (r > 64'sd8388607)       begin d = 24'h7FFFFF; s = 1'b1; end
    else if (r < -64'sd8388608) begin d = 24'h800000; s = 1'b1; end
    else                        begin d = 24'(r);     s = 1'b0; end
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One-clk strobe; predicts acceptance and, on a completing strobe, the result.
  task automatic send(input logic [23:0] d, input bit lit_en = 1'b0,
                      input int lit_val = 0, input bit lit_sat = 1'b0);
    exp_t                x;
    int unsigned         e_edge;
    logic [23:0]         md;
    logic                ms;
    logic signed [23:0]  sv;
    @(negedge clk);
    e_edge       = cyc + 1;
    bus.in_data  = d;
    bus.in_valid = 1'b1;
    if (e_edge >= free_edge) begin
      sv = {~d[23], d[22:0]};
      hist.push_front(int'(sv));
      if (hist.size() > 16) void'(hist.pop_back());
      phase = (phase + 1) % 2;
      if (phase == 0) begin
        model(md, ms);
        x.d = lit_en ? 24'(lit_val) : md;
        x.s = lit_en ? lit_sat : ms;
        x.e = e_edge + 17;
        sb.push_back(x);
        free_edge = e_edge + 18;
      end
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    sb.delete();
    hist.delete();
    phase     = 0;
    free_edge = 0;
    repeat (n) @(negedge clk);
    chk("rst_out_data",  32'(bus.out_data),  32'h0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_busy",      32'(bus.busy),      32'h0);
    chk("rst_overrun",   32'(bus.overrun),   32'h0);
    chk("rst_sat",       32'(bus.sat),       32'h0);
    rst_n = 1'b1;
  endtask

  // Scoreboard monitor: every out_valid must match the oldest expectation.
  always @(negedge clk) begin
    exp_t x;
    if (bus.out_valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("spurious_out_valid", 32'(bus.out_valid), 32'h0);
      end else begin
        x = sb.pop_front();
        chk("out_data", 32'(bus.out_data), 32'(x.d));
        chk("sat",      32'(bus.sat),      32'(x.s));
        chk("latency",  32'(cyc),          32'(x.e));
      end
    end else begin
      chk("sat_without_valid", 32'(bus.sat), 32'h0);
    end
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = 24'h800000;
    do_reset(4);

    // DC: 0x801000 every 64 clk -> 0x001000 once the window is full.
    for (int i = 1; i <= 20; i++) begin
      send(24'h801000, (i >= 16), 32'h1000, 1'b0);
      idle(62);
    end
    chk("overrun_after_dc", 32'(bus.overrun), 32'h0);

    // Impulse after midscale history: outputs walk the even-indexed taps.
    for (int i = 0; i < 17; i++) begin send(24'h800000); idle(18); end
    send(24'h800800, 1'b1, tb_coef[0], 1'b0);
    idle(18);
    for (int j = 1; j <= 16; j++) begin
      send(24'h800000, 1'b1, (j < 16) ? tb_coef[j] : 0, 1'b0);
      idle(18);
    end

    // Saturation: full-scale inputs sign-matched to the taps, then negated.
    for (int j = 0; j < 16; j++) begin
      send((tb_coef[15-j] >= 0) ? 24'hFFFFFF : 24'h000000, (j == 15), 32'h7FFFFF, 1'b1);
      idle(18);
    end
    for (int j = 0; j < 16; j++) begin
      send((tb_coef[15-j] >= 0) ? 24'h000000 : 24'hFFFFFF, (j == 15), 32'h800000, 1'b1);
      idle(18);
    end

    // Overrun: strobe 5 clk after a completing strobe is dropped.
    send(24'h801000); idle(18);
    send(24'h802000); idle(3);
    send(24'h803000); idle(20);
    chk("overrun_set", 32'(bus.overrun), 32'h1);
    send(24'h800000); idle(18);
    send(24'h800000); idle(18);
    chk("overrun_sticky", 32'(bus.overrun), 32'h1);

    // Reset mid-MAC, with a strobe landing during MAC first: no output.
    send(24'h800000); idle(18);
    send(24'h801000); idle(2);
    send(24'h804000); idle(2);
    do_reset(4);
    idle(30);

    // Rounding: acc = -1025 -> -1.
    send(24'h800000); idle(18);
    send(24'h8000CD, 1'b1, -1, 1'b0); idle(18);
    for (int i = 0; i < 16; i++) begin send(24'h800000); idle(18); end
    // acc = +1024 -> 1 (-16 at tap 4).
    send(24'h800000); idle(18);
    send(24'h7FFFF0); idle(18);
    for (int j = 1; j <= 4; j++) begin send(24'h800000, (j == 4), 1, 1'b0); idle(18); end
    for (int i = 0; i < 16; i++) begin send(24'h800000); idle(18); end
    // acc = -1024 -> 0.
    send(24'h800000); idle(18);
    send(24'h800010); idle(18);
    for (int j = 1; j <= 4; j++) begin send(24'h800000, (j == 4), 0, 1'b0); idle(18); end

    // Random CIC words against the reference model.
    repeat (1000) begin
      send(24'($urandom));
      idle(18);
    end

    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
